muller_c_pipeline: RTL and testbench

//  Clocked emulation of a DEPTH-stage Muller C-element micropipeline with a DATA_W data path.

---
 rtl/muller_c_pkg.sv | 15 +
 rtl/muller_c_stage.sv | 43 ++++
 rtl/muller_c_pipeline.sv | 94 +++++++++
 tb/tb_muller_c_pipeline.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muller_c_pkg.sv
// rtl/muller_c_pkg.sv - shared encodings and helpers for the C-element micropipeline
package muller_c_pkg;

    localparam int PH_TWO  = 2;
    localparam int PH_FOUR = 4;

    function automatic logic c_next(input logic a, input logic b, input logic c);
        return (a & b) | (c & (a | b));
    endfunction

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/muller_c_stage.sv
// rtl/muller_c_stage.sv - one C element with its data latch
module muller_c_stage
    import muller_c_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PHASES = PH_TWO
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a,
    input  logic              b,
    input  logic [DATA_W-1:0] d_in,
    output logic              c,
    output logic              c_nxt,
    output logic [DATA_W-1:0] d
);

    logic capture;

    assign c_nxt = c_next(a, b, c);

    // Return-to-zero only carries data on the rising phase; the fall is a pure ack wave.
    generate
        if (PHASES == PH_FOUR) begin : g_rtz
            assign capture = c_nxt & ~c;
        end else begin : g_nrz
            assign capture = c_nxt ^ c;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            c <= 1'b0;
            d <= '0;
        end else begin
            c <= c_nxt;
            if (capture) begin
                d <= d_in;
            end
        end
    end

endmodule

// File: rtl/muller_c_pipeline.sv
// rtl/muller_c_pipeline.sv - clocked Muller C-element micropipeline; optional MULLER_C_STALL_DETECT_EN
module muller_c_pipeline
    import muller_c_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int PHASES = PH_TWO
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_req,
    output logic                        in_ack,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        out_req,
    input  logic                        out_ack,
    output logic [DATA_W-1:0]           out_data,
    output logic [occ_width(DEPTH)-1:0] occupancy
`ifdef MULLER_C_STALL_DETECT_EN
    ,
    output logic                        stall
`endif
);

    localparam int OCC_W = occ_width(DEPTH);

    logic [DEPTH-1:0]             c;
    logic [DEPTH-1:0]             c_nxt;
    logic [DEPTH-1:0]             a_vec;
    logic [DEPTH-1:0]             b_vec;
    logic [DEPTH-1:0][DATA_W-1:0] d;
    logic [DEPTH-1:0][DATA_W-1:0] d_src;
    logic [OCC_W-1:0]             occ_nxt;

    assign a_vec = {c[DEPTH-2:0], in_req};
    assign b_vec = ~{out_ack, c[DEPTH-1:1]};
    assign d_src = {d[DEPTH-2:0], in_data};

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            muller_c_stage #(
                .DATA_W (DATA_W),
                .PHASES (PHASES)
            ) u_stage (
                .clk   (clk),
                .reset (reset),
                .a     (a_vec[i]),
                .b     (b_vec[i]),
                .d_in  (d_src[i]),
                .c     (c[i]),
                .c_nxt (c_nxt[i]),
                .d     (d[i])
            );
        end
    endgenerate

    assign in_ack   = c[0];
    assign out_req  = c[DEPTH-1];
    assign out_data = d[DEPTH-1];

    // Each adjacent disagreement in the chain is one event in flight.
    always_comb begin
        occ_nxt = '0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            occ_nxt = occ_nxt + OCC_W'(c_nxt[i] ^ c_nxt[i+1]);
        end
        occ_nxt = occ_nxt + OCC_W'(c_nxt[DEPTH-1] ^ out_ack);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_nxt;
        end
    end

`ifdef MULLER_C_STALL_DETECT_EN
    localparam int STALL_CYCLES = 16;
    localparam int STALL_W      = $clog2(STALL_CYCLES + 1);

    logic [STALL_W-1:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (reset || (out_req == out_ack)) begin
            stall_cnt <= '0;
        end else if (stall_cnt != STALL_W'(STALL_CYCLES)) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

    assign stall = (stall_cnt >= STALL_W'(STALL_CYCLES));
`endif

endmodule

// File: tb/tb_muller_c_pipeline.sv
// tb/tb_muller_c_pipeline.sv - bench for muller_c_pipeline in 2- and 4-phase builds
module tb_muller_c_pipeline;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       req2 = 1'b0, oack2 = 1'b0, ack2, oreq2;
    logic [7:0] din2 = 8'h00, dout2;
    logic [2:0] occ2;
    logic       req4 = 1'b0, oack4 = 1'b0, ack4, oreq4;
    logic [7:0] din4 = 8'h00, dout4;
    logic [2:0] occ4;
`ifdef MULLER_C_STALL_DETECT_EN
    logic       stall2, stall4;
`endif

    int         checks = 0;
    int         failures = 0;
    logic [7:0] q2[$];
    logic [7:0] q4[$];
    int         sent, rcv, p4, acc2, cons2, acc4, cons4;
    logic       prev_ack2, prev_ack4, held;
    logic [7:0] last4_exp;
    logic [7:0] vals4[2];

    always #5 clk = ~clk;

    muller_c_pipeline #(.DEPTH(4), .DATA_W(8), .PHASES(2)) u_dut2 (
        .clk       (clk),
        .reset     (reset),
        .in_req    (req2),
        .in_ack    (ack2),
        .in_data   (din2),
        .out_req   (oreq2),
        .out_ack   (oack2),
        .out_data  (dout2),
        .occupancy (occ2)
`ifdef MULLER_C_STALL_DETECT_EN
        ,
        .stall     (stall2)
`endif
    );

    muller_c_pipeline #(.DEPTH(4), .DATA_W(8), .PHASES(4)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_req    (req4),
        .in_ack    (ack4),
        .in_data   (din4),
        .out_req   (oreq4),
        .out_ack   (oack4),
        .out_data  (dout4),
        .occupancy (occ4)
`ifdef MULLER_C_STALL_DETECT_EN
        ,
        .stall     (stall4)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ack2"}, ack2, 0);
        check({tag, "_oreq2"}, oreq2, 0);
        check({tag, "_dout2"}, dout2, 0);
        check({tag, "_occ2"}, occ2, 0);
        check({tag, "_ack4"}, ack4, 0);
        check({tag, "_oreq4"}, oreq4, 0);
        check({tag, "_dout4"}, dout4, 0);
        check({tag, "_occ4"}, occ4, 0);
`ifdef MULLER_C_STALL_DETECT_EN
        check({tag, "_stall2"}, stall2, 0);
        check({tag, "_stall4"}, stall4, 0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "bench did not finish");
    end

    initial begin
        // Reset with random inputs
        for (int k = 0; k < 3; k++) begin
            req2 = 1'($urandom); oack2 = 1'($urandom); din2 = 8'($urandom);
            req4 = 1'($urandom); oack4 = 1'($urandom); din4 = 8'($urandom);
            tick();
            check_idle_outputs("reset");
        end
        req2 = 0; oack2 = 0; din2 = 0; req4 = 0; oack4 = 0; din4 = 0;
        tick();
        reset = 0;

        // Single token, 2-phase
        req2 = 1; din2 = 8'hA5;
        tick();
        check("single_in_ack", ack2, 1);
        check("single_occ", occ2, 1);
        tick(); tick();
        check("single_oreq_early", oreq2, 0);
        tick();
        check("single_oreq", oreq2, 1);
        check("single_data", dout2, 8'hA5);
        oack2 = 1;
        tick();
        check("single_occ_empty", occ2, 0);

        // Fill with consumer idle, then drain
        q2.delete();
        sent = 0;
        for (int n = 0; n < 30; n++) begin
            if (ack2 == req2 && sent < 5) begin
                sent++;
                req2 = ~req2;
                din2 = 8'(sent);
                q2.push_back(din2);
            end
            tick();
        end
        check("fill_occ", occ2, 4);
        check("fill_pending", 32'(ack2 != req2), 1);
        check("fill_head", dout2, 8'h01);
        held = ack2;
        repeat (4) tick();
        check("fill_ack_frozen", ack2, held);
        rcv = 0;
        for (int n = 0; n < 60 && rcv < 5; n++) begin
            if (oreq2 != oack2) begin
                check("drain_data", dout2, q2.pop_front());
                rcv++;
                oack2 = ~oack2;
            end
            tick();
        end
        check("drain_count", rcv, 5);
        check("drain_occ", occ2, 0);
        check("drain_empty", 32'(oreq2 == oack2), 1);

        // 4-phase: two full return-to-zero cycles
        vals4[0] = 8'h3C; vals4[1] = 8'hC3;
        p4 = 0; rcv = 0; last4_exp = 8'h00;
        for (int n = 0; n < 100 && (p4 < 4 || rcv < 4); n++) begin
            if (ack4 == req4 && p4 < 4) begin
                req4 = ~req4;
                if (req4) din4 = vals4[p4/2];
                p4++;
            end
            if (oreq4 != oack4) begin
                if (oreq4) begin
                    last4_exp = vals4[rcv/2];
                    check("p4_rise_data", dout4, last4_exp);
                end else begin
                    check("p4_fall_data", dout4, last4_exp);
                end
                rcv++;
                oack4 = ~oack4;
            end
            tick();
        end
        check("p4_events", rcv, 4);
        check("p4_occ", occ4, 0);

        // Reset with two tokens in flight
        for (int t = 0; t < 2; t++) begin
            req2 = ~req2;
            din2 = 8'(8'h10 + t);
            for (int n = 0; n < 10 && ack2 != req2; n++) tick();
            check("mid_accept", 32'(ack2 == req2), 1);
        end
        check("mid_occ", occ2, 2);
        reset = 1; req2 = 0; oack2 = 0; din2 = 0;
        tick();
        check_idle_outputs("mid_reset");
        reset = 0; req2 = 1; din2 = 8'h5A;
        tick();
        check("post_in_ack", ack2, 1);
        tick(); tick();
        check("post_oreq_early", oreq2, 0);
        tick();
        check("post_oreq", oreq2, 1);
        check("post_data", dout2, 8'h5A);
        oack2 = 1;
        tick();
        check("post_occ", occ2, 0);

        // Random producer/consumer against a token scoreboard
        q2.delete(); q4.delete();
        acc2 = 0; cons2 = 0; acc4 = 0; cons4 = 0;
        prev_ack2 = req2; prev_ack4 = req4; last4_exp = 8'hC3;
        for (int n = 0; n < 480; n++) begin
            acc2 += int'(ack2 != prev_ack2); prev_ack2 = ack2;
            acc4 += int'(ack4 != prev_ack4); prev_ack4 = ack4;
            check("rand2_occ", occ2, acc2 - cons2);
            check("rand4_occ", occ4, acc4 - cons4);
            if (n < 400 && ack2 == req2 && $urandom_range(0, 1) == 1) begin
                req2 = ~req2;
                din2 = 8'($urandom);
                q2.push_back(din2);
            end
            if (n < 400 && ack4 == req4 && $urandom_range(0, 1) == 1) begin
                req4 = ~req4;
                if (req4) begin
                    din4 = 8'($urandom);
                    q4.push_back(din4);
                end
            end
            if (oreq2 != oack2 && (n >= 400 || $urandom_range(0, 2) != 0)) begin
                check("rand2_avail", 32'(q2.size() != 0), 1);
                if (q2.size() != 0) check("rand2_data", dout2, q2.pop_front());
                cons2++;
                oack2 = ~oack2;
            end
            if (oreq4 != oack4 && (n >= 400 || $urandom_range(0, 2) != 0)) begin
                if (oreq4) begin
                    check("rand4_avail", 32'(q4.size() != 0), 1);
                    if (q4.size() != 0) last4_exp = q4.pop_front();
                    check("rand4_rise_data", dout4, last4_exp);
                end else begin
                    check("rand4_fall_data", dout4, last4_exp);
                end
                cons4++;
                oack4 = ~oack4;
            end
            tick();
        end
        check("rand2_left", q2.size(), 0);
        check("rand4_left", q4.size(), 0);
        check("rand2_final_occ", occ2, 0);
        check("rand4_final_occ", occ4, 0);

`ifdef MULLER_C_STALL_DETECT_EN
        // Consumer stuck: stall after 16 waiting cycles, clears one cycle after ack
        req2 = ~req2; din2 = 8'h77;
        for (int n = 0; n < 12 && oreq2 == oack2; n++) tick();
        check("stall_req_out", 32'(oreq2 != oack2), 1);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 15) check("stall_early", stall2, 0);
            if (k == 16) check("stall_set", stall2, 1);
            if (k == 20) check("stall_hold", stall2, 1);
        end
        oack2 = ~oack2;
        tick();
        check("stall_clear", stall2, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
